// File: rtl/hd_tzmask_serial_pkg.sv
// Shared types and helpers for the serial trailing-zero-mask block.
// Optional ctz counter is enabled with the HD_CTZ_COUNT_EN macro.
package hd_pkg;

  typedef enum logic [1:0] {
    HD_IDLE = 2'd0,
    HD_BUSY = 2'd1,
    HD_DONE = 2'd2
  } hd_state_e;

  // Number of chunk cycles needed to resolve one operand.
  function automatic int hd_nchunk(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

  // Width of a count that must reach WIDTH (all-zero operand).
  function automatic int hd_ctz_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hd_tzmask_serial_if.sv
// Operand/result bus of hd_tzmask_serial. out_ctz exists only when
// HD_CTZ_COUNT_EN is defined. The state field mirrors the internal FSM.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its data steady until that edge;
// the sink may raise or lower ready freely. Here in_valid/in_ready carry
// operands into the block and out_valid/out_ready carry results out.
interface hd_tzmask_serial_if
  import hd_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic             out_zero;
`ifdef HD_CTZ_COUNT_EN
  localparam int CTZ_W = hd_ctz_w(WIDTH);
  logic [CTZ_W-1:0] out_ctz;
`endif
  hd_state_e        state;

`ifdef HD_CTZ_COUNT_EN
  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_mask, out_zero, out_ctz, state
  );
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_mask, out_zero, out_ctz, state
  );
`else
  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_mask, out_zero, state
  );
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_mask, out_zero, state
  );
`endif

endinterface

// File: rtl/hd_tzmask_serial_chunk.sv
// One CHUNK-bit slice of the trailing-zero mask: a ripple of the
// "all lower bits zero" flag through the slice, LSB first.
// With HD_CTZ_COUNT_EN the slice also reports how many mask bits it set.
module hd_tz_chunk
  import hd_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]           x_chunk,
  input  logic                       allz_in,
  output logic [CHUNK-1:0]           m_chunk,
  output logic                       allz_out
`ifdef HD_CTZ_COUNT_EN
  ,
  output logic [$clog2(CHUNK+1)-1:0] pop
`endif
);

`ifdef HD_CTZ_COUNT_EN
  localparam int PW = $clog2(CHUNK + 1);
`endif

  // Ripple the carry flag: a bit is in the mask only if it and every lower bit are zero.
  always_comb begin
    logic a;
    m_chunk = '0;
    a       = allz_in;
    for (int j = 0; j < CHUNK; j++) begin
      m_chunk[j] = a & ~x_chunk[j];
      a          = m_chunk[j];
    end
    allz_out = a;
  end

`ifdef HD_CTZ_COUNT_EN
  // Count the mask bits set in this slice.
  always_comb begin
    pop = '0;
    for (int j = 0; j < CHUNK; j++) begin
      pop = pop + PW'(m_chunk[j]);
    end
  end
`endif

endmodule

// File: rtl/hd_tzmask_serial.sv
// Serial trailing-zero mask m = ~x & (x - 1), CHUNK bits per cycle.
// An accepted operand is latched, then resolved LSB chunk first over
// NCHUNK cycles while a carry flag tracks "all lower bits zero". The
// result is then held until the consumer takes it.
// Optional: HD_CTZ_COUNT_EN adds out_ctz, the trailing-zero count.
module hd_tzmask_serial
  import hd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst_n,
  hd_tzmask_serial_if.slave hd
);

  localparam int NCHUNK = hd_nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
`ifdef HD_CTZ_COUNT_EN
  localparam int CTZ_W  = hd_ctz_w(WIDTH);
  localparam int PW     = $clog2(CHUNK + 1);
`endif

  // Reject configurations that cannot be split into whole chunks.
  if (WIDTH < 1) begin : g_bad_width
    $error("hd_tzmask_serial: WIDTH must be >= 1");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("hd_tzmask_serial: CHUNK must divide WIDTH");
  end

  hd_state_e        state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] mask_q;
  logic             allz_q;
  logic [KW-1:0]    k_q;
`ifdef HD_CTZ_COUNT_EN
  logic [CTZ_W-1:0] ctz_q;
  logic [PW-1:0]    pop;
`endif

  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] m_chunk;
  logic             allz_nxt;

  // Select the operand slice for the current chunk index.
  always_comb begin
    x_chunk = x_q[k_q*CHUNK +: CHUNK];
  end

  hd_tz_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x_chunk (x_chunk),
    .allz_in (allz_q),
    .m_chunk (m_chunk),
    .allz_out(allz_nxt)
`ifdef HD_CTZ_COUNT_EN
    ,
    .pop     (pop)
`endif
  );

  // Control FSM plus operand, mask, index, carry and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HD_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      mask_q      <= '0;
      allz_q      <= 1'b0;
      k_q         <= '0;
`ifdef HD_CTZ_COUNT_EN
      ctz_q       <= '0;
`endif
    end else begin
      case (state_q)
        HD_IDLE: begin
          if (hd.in_valid) begin
            x_q        <= hd.in_x;
            k_q        <= '0;
            allz_q     <= 1'b1;
`ifdef HD_CTZ_COUNT_EN
            ctz_q      <= '0;
`endif
            state_q    <= HD_BUSY;
            in_ready_q <= 1'b0;
          end
        end
        HD_BUSY: begin
          mask_q[k_q*CHUNK +: CHUNK] <= m_chunk;
          allz_q                     <= allz_nxt;
`ifdef HD_CTZ_COUNT_EN
          ctz_q                      <= ctz_q + CTZ_W'(pop);
`endif
          if (k_q == K_LAST) begin
            k_q         <= '0;
            state_q     <= HD_DONE;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        HD_DONE: begin
          // The result drains here; the next operand waits for IDLE.
          if (hd.out_ready) begin
            state_q     <= HD_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= HD_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign hd.in_ready  = in_ready_q;
  assign hd.out_valid = out_valid_q;
  assign hd.out_mask  = mask_q;
  assign hd.out_zero  = allz_q;
  assign hd.state     = state_q;
`ifdef HD_CTZ_COUNT_EN
  assign hd.out_ctz   = ctz_q;
`endif

endmodule
